// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Purpose  : Multi-channel runtime-programmable tick generator. Each channel
//            has its own period register, enable and restart, and produces a
//            one-cycle tick strobe and a 50% toggled divided clock level.
// Revision : 1.0  initial release
// ============================================================================
module tick_divider #(
    parameter int NCH        = 4,
    parameter int CW         = 25,
    parameter int DEF_PERIOD = 2500,
    localparam int C_WCW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    restart,
    input  logic              wr_en,
    input  logic [C_WCW-1:0]  wr_ch,
    input  logic [CW-1:0]     wr_period,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    clk_div,
    output logic [NCH*CW-1:0] period_rd
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] r_period;
        logic [CW-1:0] r_cnt;
        logic          r_tick;
        logic          r_div;
        logic          w_wr_hit;
        logic          w_halted;
        logic          w_term;

        // Out-of-range channel indices never match any channel, so they are
        // silently dropped.
        assign w_wr_hit = wr_en && (wr_ch == C_WCW'(i));
        assign w_halted = !en[i] || (r_period == '0);
        // The decrement only matters when the period is non-zero, so the
        // wrapped value for period 0 is masked off and can never match.
        assign w_term   = (r_period != '0) && (r_cnt == (r_period - CW'(1)));

        // Per-channel counter, period register and output flops, evaluated
        // in priority: write, restart, halted, terminal count, count.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_period <= CW'(DEF_PERIOD);
                r_cnt    <= '0;
                r_tick   <= 1'b0;
                r_div    <= 1'b0;
            end else if (w_wr_hit) begin
                r_period <= wr_period;
                r_cnt    <= '0;
                r_tick   <= 1'b0;
            end else if (restart[i]) begin
                r_cnt    <= '0;
                r_tick   <= 1'b0;
            end else if (w_halted) begin
                r_tick   <= 1'b0;
            end else if (w_term) begin
                r_cnt    <= '0;
                r_tick   <= 1'b1;
                r_div    <= ~r_div;
            end else begin
                r_cnt    <= r_cnt + CW'(1);
                r_tick   <= 1'b0;
            end
        end

        assign tick[i]                 = r_tick;
        assign clk_div[i]              = r_div;
        assign period_rd[i*CW +: CW]   = r_period;
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_divider
// Purpose  : Self-checking bench for tick_divider: table-driven reset
//            sequence, hand-written corner cases and randomized traffic
//            compared against an edge-counting reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tick_divider;
    localparam int NCH = 3;
    localparam int CW  = 6;
    localparam int DEF = 4;
    localparam int WCW = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NCH-1:0]    en = '0;
    logic [NCH-1:0]    restart = '0;
    logic              wr_en = 1'b0;
    logic [WCW-1:0]    wr_ch = '0;
    logic [CW-1:0]     wr_period = '0;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    clk_div;
    logic [NCH*CW-1:0] period_rd;

    tick_divider #(.NCH(NCH), .CW(CW), .DEF_PERIOD(DEF)) dut (
        .CLK(CLK), .RST(RST), .en(en), .restart(restart), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_period(wr_period), .tick(tick),
        .clk_div(clk_div), .period_rd(period_rd)
    );

    // free-running clock, period 10
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: counts enabled edges since the last clear; a tick is
    // due whenever that count is a multiple of the period, and the divided
    // level is the clear-time level flipped once per completed period.
    int m_per   [NCH];
    int m_edges [NCH];
    bit m_tick  [NCH];
    bit m_div   [NCH];
    bit m_base  [NCH];

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] exp_tick;
        logic [NCH-1:0] exp_div;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_per[i] = DEF; m_edges[i] = 0; m_tick[i] = 0; m_div[i] = 0; m_base[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            if (wr_en && (int'(wr_ch) == i)) begin
                m_per[i] = int'(wr_period); m_edges[i] = 0; m_base[i] = m_div[i]; m_tick[i] = 0;
            end else if (restart[i]) begin
                m_edges[i] = 0; m_base[i] = m_div[i]; m_tick[i] = 0;
            end else if (!en[i] || m_per[i] == 0) begin
                m_tick[i] = 0;
            end else begin
                m_edges[i]++;
                m_tick[i] = (m_edges[i] % m_per[i]) == 0;
                m_div[i]  = m_base[i] ^ bit'((m_edges[i] / m_per[i]) % 2);
            end
        end
    endtask

    task automatic model_check();
        logic [NCH-1:0]    et;
        logic [NCH-1:0]    ed;
        logic [NCH*CW-1:0] ep;
        for (int i = 0; i < NCH; i++) begin
            et[i] = m_tick[i];
            ed[i] = m_div[i];
            ep[i*CW +: CW] = CW'(m_per[i]);
        end
        check("model_tick", 64'(tick), 64'(et));
        check("model_clk_div", 64'(clk_div), 64'(ed));
        check("model_period_rd", 64'(period_rd), 64'(ep));
    endtask

    // one clock edge with current inputs, then compare against the model
    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        model_check();
    endtask

    task automatic write(input int ch, input int n);
        wr_en = 1'b1; wr_ch = WCW'(ch); wr_period = CW'(n);
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic d;
        logic [NCH*CW-1:0] prd;

        for (int k = 0; k < 12; k++) begin
            tbl[k].en       = '1;
            tbl[k].exp_tick = ((k + 1) % 4 == 0) ? '1 : '0;
            tbl[k].exp_div  = (((k + 1) / 4) % 2 == 1) ? '1 : '0;
        end

        // reset state
        model_reset();
        #22;
        check("reset_tick", 64'(tick), 64'(0));
        check("reset_clk_div", 64'(clk_div), 64'(0));
        check("reset_period", 64'(period_rd), 64'({NCH{CW'(DEF)}}));
        en  = '1;
        RST = 1'b0;

        // default period 4 after release: ticks on cycles 4, 8, 12
        for (int k = 0; k < 12; k++) begin
            en = tbl[k].en;
            step();
            check($sformatf("tbl_tick[%0d]", k + 1), 64'(tick), 64'(tbl[k].exp_tick));
            check($sformatf("tbl_div[%0d]", k + 1), 64'(clk_div), 64'(tbl[k].exp_div));
        end

        // runtime write on channel 1 mid-count
        write(1, 10);
        for (int k = 0; k < 6; k++) step();
        write(1, 3);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("wr_tick1_k%0d", k), 64'(tick[1]), 64'(k == 3 || k == 6));
        end

        // restart colliding with terminal count on channel 2
        write(2, 5);
        for (int k = 0; k < 4; k++) step();
        d = clk_div[2];
        restart = 3'b100;
        step();
        restart = '0;
        check("rst_coll_tick2", 64'(tick[2]), 64'(0));
        check("rst_coll_div2", 64'(clk_div[2]), 64'(d));
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("rst_tick2_k%0d", k), 64'(tick[2]), 64'(k == 5));
        end

        // enable gating on channel 0
        write(0, 8);
        for (int k = 0; k < 5; k++) step();
        en[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check("gate_tick0", 64'(tick[0]), 64'(0));
        end
        en[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("gate_resume_k%0d", k), 64'(tick[0]), 64'(k == 3));
        end

        // boundary periods: 1, 0 and 2^CW-1
        write(0, 1);
        for (int k = 0; k < 6; k++) begin
            d = clk_div[0];
            step();
            check("n1_tick", 64'(tick[0]), 64'(1));
            check("n1_toggle", 64'(clk_div[0]), 64'(!d));
        end
        write(1, 0);
        d = clk_div[1];
        for (int k = 0; k < 10; k++) begin
            step();
            check("n0_tick", 64'(tick[1]), 64'(0));
            check("n0_div", 64'(clk_div[1]), 64'(d));
        end
        write(2, 63);
        for (int k = 1; k <= 63; k++) begin
            step();
            check($sformatf("nmax_k%0d", k), 64'(tick[2]), 64'(k == 63));
        end

        // asynchronous reset between edges
        write(0, 7);
        for (int k = 0; k < 3; k++) step();
        RST = 1'b1;
        model_reset();
        #2;
        check("async_tick", 64'(tick), 64'(0));
        check("async_div", 64'(clk_div), 64'(0));
        check("async_period", 64'(period_rd), 64'({NCH{CW'(DEF)}}));
        @(posedge CLK);
        #1;
        model_check();
        RST = 1'b0;

        // out-of-range write index
        prd = period_rd;
        wr_en = 1'b1; wr_ch = 2'd3; wr_period = 6'd9;
        step();
        wr_en = 1'b0;
        check("bad_index", 64'(period_rd), 64'(prd));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                en[i]      = ($urandom_range(0, 99) < 85);
                restart[i] = ($urandom_range(0, 99) < 3);
            end
            wr_en = ($urandom_range(0, 99) < 5);
            wr_ch = WCW'($urandom_range(0, 3));
            wr_period = ($urandom_range(0, 9) < 7) ? CW'($urandom_range(0, 6))
                                                   : CW'($urandom_range(0, 63));
            step();
        end
        wr_en = 1'b0; restart = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
